uart_recv: RTL and testbench
============================

UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 SHALL have parameter CLK_IN, default 50_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port bps_set, input, 2 bits: baud select; 00=9600, 01=19200, 10=38400, 11=921600.
REQ-005 SHALL have port rs232_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port data_in, output, 8 bits: last received byte.
REQ-007 SHALL have port rx_done, output, 1 bit: one-cycle pulse per completed frame.
REQ-008 SHALL have port rx_state, output, 1 bit: 1 while a frame is in progress.
REQ-009 SHALL have port parity_err, output, 1 bit: parity status of the last frame.
REQ-010 SHALL have port frame_err, output, 1 bit: stop-bit status of the last frame.

Function
REQ-011 SHALL pass rs232_rx through a 2-FF synchronizer (reset value 1) before any use.
REQ-012 SHALL detect a start as a synchronized 1->0 transition while in IDLE.
- Cycle of detection is t0.
REQ-013 SHALL latch the divisor N-1 at t0; bps_set changes mid-frame have no effect.
- N-1 = CLK_IN/baud-1, i.e. 5207, 2603, 1301 or 53 at 50 MHz.
- Bit counter is 13 bits wide.
REQ-014 SHALL take one sample per bit at t0 + N/2 + k*N (integer division), where k is:
- 0 for start;
- 1..8 for data, LSB first;
- 9 for parity;
- 10 for stop (9 when parity is compiled out).
REQ-015 SHALL use states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE -> START on start detect.
- START -> IDLE if the start sample is 1 (false start: no rx_done, no flag change); otherwise START -> DATA.
- DATA -> PARITY after the 8th data sample.
- PARITY -> STOP after the parity sample.
- STOP -> IDLE if the stop sample is 1; STOP -> WAIT_IDLE if it is 0.
- WAIT_IDLE -> IDLE on the first synchronized high.
REQ-016 SHALL assert rx_done for exactly one cycle, the cycle after the stop sample.
- data_in, parity_err and frame_err update in that same cycle and hold until the next rx_done.
REQ-017 SHALL use even parity: parity_err = XOR of the 8 data bits and the parity bit.
REQ-018 SHALL set frame_err = 1 when the stop sample is 0; data_in is still updated.
REQ-019 SHALL drive rx_state = 1 in START, DATA, PARITY, STOP and WAIT_IDLE, and 0 in IDLE (registered, one-cycle lag allowed).
REQ-020 SHALL accept a new start edge in the cycle after returning to IDLE, so back-to-back frames with one stop bit are received without loss.

Reset
REQ-021 SHALL, on rst, force:
- state = IDLE;
- data_in = 0x00;
- rx_done, rx_state, parity_err and frame_err = 0;
- synchronizer flops = 1;
- all counters = 0.
REQ-022 SHALL, on rst mid-frame, abandon the frame with no rx_done and require a fresh falling edge after reset release.

Configuration
REQ-023 SHALL implement the parity stage only when UART_RECV_PARITY_EN is defined.
- Defined: 11-bit frame, PARITY state present, parity_err computed per REQ-017.
- Undefined: 10-bit frame, DATA -> STOP directly, parity_err tied 0.

Structure
REQ-024 SHALL take divisor constants, the baud-select encoding and the state encoding from shared package uart_pkg, which is shared with the transmitter.
REQ-025 SHALL instantiate one sub-module, uart_rx_sync, containing the 2-FF synchronizer and the falling-edge detect; the rest stays in uart_recv.

Verification
REQ-026 SHALL cover: bps_set=00, frame 0xA5 with parity 0 and stop 1 -> one rx_done pulse 1 cycle after the stop sample, data_in=0xA5, parity_err=0, frame_err=0.
REQ-027 SHALL cover: bps_set=11, frame 0x01 with parity 0 -> data_in=0x01, parity_err=1.
REQ-028 SHALL cover: bps_set=01, frame 0x3C with stop 0, line held low 3 bit times -> frame_err=1, rx_done once, rx_state=1 until the line goes high.
REQ-029 SHALL cover: bps_set=00, rs232_rx low for 1000 cycles -> no rx_done, rx_state returns to 0, flags unchanged.
REQ-030 SHALL cover: bps_set=10, rst asserted at data bit 4 -> no rx_done, all outputs 0; a following frame 0x5A is received correctly.
REQ-031 SHALL cover: bps_set=11, frames 0x00, 0xFF and 0x55 sent back-to-back -> three rx_done pulses with matching data_in and no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART baud-select encoding, divisor helper and receiver state encoding shared with the transmitter
package uart_pkg;

  localparam int CNT_W = 13;

  localparam logic [1:0] BPS_9600   = 2'b00;
  localparam logic [1:0] BPS_19200  = 2'b01;
  localparam logic [1:0] BPS_38400  = 2'b10;
  localparam logic [1:0] BPS_921600 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Clock cycles per bit minus one for a given clock and baud select.
  function automatic logic [CNT_W-1:0] bps_div(input int clk_hz, input logic [1:0] sel);
    int baud;
    case (sel)
      BPS_9600:  baud = 9600;
      BPS_19200: baud = 19200;
      BPS_38400: baud = 38400;
      default:   baud = 921600;
    endcase
    return CNT_W'(clk_hz / baud - 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-FF synchronizer for the serial line plus falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_o,
  output logic fall_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic       armed_q;
  logic [1:0] vld_q;

  // The edge detector stays disarmed until a genuine high has passed through the
  // synchronizer, so a line held low across reset release is not taken as a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & sync_q);
    end
  end

  assign rx_o   = sync_q;
  assign fall_o = armed_q & prev_q & ~sync_q;

endmodule

// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - UART receiver, 8 data bits LSB first, 1 stop bit
// Even parity stage present only when UART_RECV_PARITY_EN is defined.
module uart_recv
  import uart_pkg::*;
#(
  parameter int CLK_IN = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bps_set,
  input  logic       rs232_rx,
  output logic [7:0] data_in,
  output logic       rx_done,
  output logic       rx_state,
  output logic       parity_err,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] DIV_9600   = bps_div(CLK_IN, BPS_9600);
  localparam logic [CNT_W-1:0] DIV_19200  = bps_div(CLK_IN, BPS_19200);
  localparam logic [CNT_W-1:0] DIV_38400  = bps_div(CLK_IN, BPS_38400);
  localparam logic [CNT_W-1:0] DIV_921600 = bps_div(CLK_IN, BPS_921600);

  logic             rx_s;
  logic             fall;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d, div_sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             rx_state_q;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
`ifdef UART_RECV_PARITY_EN
  logic             par_q, par_d;
`endif
  logic [CNT_W:0]   div_p1;
  logic [CNT_W-1:0] half_m1;
  logic             bit_tick;
  logic             half_tick;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rs232_rx),
    .rx_o   (rx_s),
    .fall_o (fall)
  );

  always_comb begin
    case (bps_set)
      BPS_9600:  div_sel = DIV_9600;
      BPS_19200: div_sel = DIV_19200;
      BPS_38400: div_sel = DIV_38400;
      default:   div_sel = DIV_921600;
    endcase
  end

  // cnt_q is zero in the cycle after t0, so the start sample lands at t0 + N/2.
  assign div_p1    = {1'b0, div_q} + (CNT_W+1)'(1);
  assign half_m1   = div_p1[CNT_W:1] - CNT_W'(1);
  assign bit_tick  = (cnt_q == div_q);
  assign half_tick = (cnt_q == half_m1);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
`ifdef UART_RECV_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
          div_d   = div_sel;
        end
      end
      S_START: begin
        if (half_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RECV_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RECV_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          data_d  = shift_q;
          ferr_d  = ~rx_s;
`ifdef UART_RECV_PARITY_EN
          perr_d  = ^{shift_q, par_q};
`else
          perr_d  = 1'b0;
`endif
          state_d = rx_s ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      rx_state_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RECV_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      rx_state_q <= (state_d != S_IDLE);
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
`ifdef UART_RECV_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign data_in    = data_q;
  assign rx_done    = done_q;
  assign rx_state   = rx_state_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - self-checking bench for uart_recv (honours UART_RECV_PARITY_EN)
module tb_uart_recv;

  localparam int CLK_HZ = 23_040_000;
`ifdef UART_RECV_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         c;
  } rec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] b;
    logic       p;
    logic       s;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bps_set;
  logic       rs232_rx;
  logic [7:0] data_in;
  logic       rx_done;
  logic       rx_state;
  logic       parity_err;
  logic       frame_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  rec_t rxq[$];
  rec_t expq[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  uart_recv #(.CLK_IN(CLK_HZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bps_set    (bps_set),
    .rs232_rx   (rs232_rx),
    .data_in    (data_in),
    .rx_done    (rx_done),
    .rx_state   (rx_state),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rx_done === 1'b1) rxq.push_back('{data_in, parity_err, frame_err, cyc});

  function automatic int baud_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 9600;
      2'b01:   return 19200;
      2'b10:   return 38400;
      default: return 921600;
    endcase
  endfunction

  function automatic rec_t model(input logic [7:0] b, input logic p, input logic s);
    rec_t r;
    int   ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    r.d  = b;
    r.pe = PAR_EN ? (((ones + int'(p)) % 2) == 1) : 1'b0;
    r.fe = !s;
    r.c  = 0;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Drives one frame, each bit exactly N cycles; abort_bit >= 0 stops before that bit index.
  task automatic send_frame(input logic [1:0] sel, input logic [7:0] b, input logic p, input logic s,
                            input logic [7:0] ed, input logic ep, input logic ef,
                            input int abort_bit, input bit jitter);
    int          n;
    int          nb;
    int          start;
    logic [10:0] bits;
    n     = CLK_HZ / baud_of(sel);
    nb    = PAR_EN ? 11 : 10;
    bits  = PAR_EN ? {s, p, b, 1'b0} : {1'b0, s, b, 1'b0};
    bps_set = sel;
    start = cyc;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_bit) return;
      rs232_rx = bits[i];
      if (i == 1 && jitter) bps_set = 2'($urandom);
      wait_cyc(n);
    end
    expq.push_back('{ed, ep, ef, start + 3 + n / 2 + (nb - 1) * n});
  endtask

  task automatic drain(input string tag);
    rec_t a;
    rec_t e;
    check({tag, " done_count"}, rxq.size(), expq.size());
    while (rxq.size() > 0 && expq.size() > 0) begin
      a = rxq.pop_front();
      e = expq.pop_front();
      check({tag, " data_in"}, a.d, e.d);
      check({tag, " parity_err"}, a.pe, e.pe);
      check({tag, " frame_err"}, a.fe, e.fe);
      check({tag, " done_cycle"}, a.c, e.c);
    end
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    rec_t       m;
    logic [7:0] b;
    logic       p;
    logic       s;

    rst      = 1'b1;
    rs232_rx = 1'b1;
    bps_set  = 2'b00;
    vecs[0] = '{2'b00, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 8'h01, 1'b0, 1'b1, 8'h01, PAR_EN, 1'b0};
    vecs[2] = '{2'b11, 8'hC3, 1'b1, 1'b1, 8'hC3, PAR_EN, 1'b0};
    vecs[3] = '{2'b11, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};

    wait_cyc(3);
    check("reset data_in", data_in, 8'h00);
    check("reset rx_done", rx_done, 1'b0);
    check("reset rx_state", rx_state, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_cyc(10);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].sel, vecs[i].b, vecs[i].p, vecs[i].s,
                 vecs[i].ed, vecs[i].ep, vecs[i].ef, -1, 1'b0);
      wait_cyc(4);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d rx_state idle", i), rx_state, 1'b0);
    end

    // stop bit 0, line kept low for three bit times in total
    send_frame(2'b01, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 1'b0);
    wait_cyc(2 * (CLK_HZ / 19200));
    check("break rx_state held", rx_state, 1'b1);
    drain("break");
    rs232_rx = 1'b1;
    wait_cyc(4);
    check("break rx_state released", rx_state, 1'b0);

    // false start: low for 1000 cycles, well under half a bit at 9600
    bps_set  = 2'b00;
    rs232_rx = 1'b0;
    wait_cyc(500);
    check("false start rx_state busy", rx_state, 1'b1);
    wait_cyc(500);
    rs232_rx = 1'b1;
    wait_cyc(1400);
    check("false start rx_state", rx_state, 1'b0);
    check("false start data_in", data_in, 8'h3C);
    check("false start frame_err", frame_err, 1'b1);
    check("false start parity_err", parity_err, 1'b0);
    drain("false start");

    // reset at data bit 4, line low across release, then a clean frame
    send_frame(2'b10, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    check("midreset data_in", data_in, 8'h00);
    check("midreset rx_done", rx_done, 1'b0);
    check("midreset rx_state", rx_state, 1'b0);
    check("midreset parity_err", parity_err, 1'b0);
    check("midreset frame_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_cyc(400);
    rs232_rx = 1'b1;
    wait_cyc(1200);
    send_frame(2'b10, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, -1, 1'b0);
    wait_cyc(4);
    drain("after reset");

    send_frame(2'b11, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, -1, 1'b0);
    send_frame(2'b11, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, -1, 1'b0);
    send_frame(2'b11, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, -1, 1'b0);
    wait_cyc(4);
    drain("back2back");

    for (int k = 0; k < 16; k++) begin
      b = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      m = model(b, p, s);
      send_frame(2'b11, b, p, s, m.d, m.pe, m.fe, -1, 1'b1);
      rs232_rx = 1'b1;
      if (!s) wait_cyc($urandom_range(3, 30));
      else    wait_cyc($urandom_range(0, 30));
    end
    wait_cyc(4);
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
